// File: rtl/alu8_pkg.sv
// alu8_pkg: opcodes and pipeline payload shared by the ALU slice.
package alu8_pkg;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_NEG = 4'd3;
    localparam logic [3:0] OP_AND = 4'd8;
    localparam logic [3:0] OP_XOR = 4'd9;
    localparam logic [3:0] OP_OR  = 4'd10;
    localparam logic [3:0] OP_NOT = 4'd11;
    localparam logic [3:0] OP_SHR = 4'd12;
    localparam logic [3:0] OP_SHL = 4'd13;
    localparam logic [3:0] OP_ROR = 4'd14;
    localparam logic [3:0] OP_ROL = 4'd15;

    typedef struct packed {
        logic [7:0] result;
        logic       carry;
        logic       eq;
        logic       gt;
        logic       lt;
    } payload_t;
endpackage

// File: rtl/alu8_core.sv
// alu8_core: combinational opcode decode, adder, logic, shifter and comparator.
module alu8_core
    import alu8_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] sel,
    output logic [7:0] result,
`ifdef ALU_CMP_FLAGS_EN
    output logic       eq,
    output logic       gt,
    output logic       lt,
`endif
    output logic       carry
);
    logic [8:0] sum, dif, neg;
    assign sum = {1'b0, a} + {1'b0, b};
    assign dif = {1'b0, a} - {1'b0, b};
    assign neg = {1'b0, ~b} + 9'd1;
    // opcodes 0-7 alias on the low two bits
    always_comb begin
        {carry, result} = 9'd0;
        case (sel[3] ? sel : {2'b00, sel[1:0]})
            OP_ADD:  {carry, result} = sum;
            OP_SUB:  {carry, result} = dif;
            OP_NEG:  {carry, result} = neg;
            OP_AND:  result = a & b;
            OP_XOR:  result = a ^ b;
            OP_OR:   result = a | b;
            OP_NOT:  result = ~b;
            OP_SHR:  result = {1'b0, a[7:1]};
            OP_SHL:  result = {a[6:0], 1'b0};
            OP_ROR:  result = {a[0], a[7:1]};
            OP_ROL:  result = {a[6:0], a[7]};
            default: result = 8'h00;
        endcase
    end
`ifdef ALU_CMP_FLAGS_EN
    assign eq = a == b;
    assign gt = a > b;
    assign lt = a < b;
`endif
endmodule

// File: rtl/alu8_struct.sv
// alu8_struct: pipelined 8-bit ALU, PIPE_STAGES register stages input to output.
// Define ALU_CMP_FLAGS_EN to compute and pipeline the equal/greater/smaller flags.
module alu8_struct
    import alu8_pkg::*;
#(
    parameter int PIPE_STAGES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [3:0] ALU_Sel,
    output logic [7:0] ALU_Out,
    output logic       equal,
    output logic       greater,
    output logic       smaller,
    output logic       CarryOut
);
    logic [7:0] a_q, b_q, res;
    logic [3:0] sel_q;
    logic       vld_q, cy;
    // vld_q keeps reset zeros in the input register from producing eq=1
    always_ff @(posedge clk)
        if (rst_n) {vld_q, a_q, b_q, sel_q} <= '0;
        else {vld_q, a_q, b_q, sel_q} <= {1'b1, A, B, ALU_Sel};
`ifdef ALU_CMP_FLAGS_EN
    logic     eq, gt, lt;
    payload_t nxt, out;
    alu8_core u_core (.a(a_q), .b(b_q), .sel(sel_q), .result(res), .eq(eq), .gt(gt), .lt(lt), .carry(cy));
    assign nxt = vld_q ? {res, cy, eq, gt, lt} : '0;
    assign {ALU_Out, CarryOut, equal, greater, smaller} = out;
`else
    logic [8:0] nxt, out;
    alu8_core u_core (.a(a_q), .b(b_q), .sel(sel_q), .result(res), .carry(cy));
    assign nxt = vld_q ? {res, cy} : '0;
    assign {ALU_Out, CarryOut} = out;
    assign {equal, greater, smaller} = 3'b000;
`endif
    localparam int W = $bits(nxt);
    if (PIPE_STAGES == 1) begin : g_direct
        assign out = nxt;
    end else begin : g_pipe
        logic [W-1:0] pipe [PIPE_STAGES-1];
        always_ff @(posedge clk)
            if (rst_n) begin
                for (int i = 0; i < PIPE_STAGES - 1; i++) pipe[i] <= '0;
            end else begin
                pipe[0] <= nxt;
                for (int i = 1; i < PIPE_STAGES - 1; i++) pipe[i] <= pipe[i-1];
            end
        assign out = pipe[PIPE_STAGES-2];
    end
endmodule

// File: tb/tb_alu8_struct.sv
// tb_alu8_struct: table-driven and randomized checks of alu8_struct against a latency queue model.
module tb_alu8_struct;
    localparam int LAT = 7;
`ifdef ALU_CMP_FLAGS_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif
    typedef struct packed {
        logic [7:0] r;
        logic       c;
        logic       eq;
        logic       gt;
        logic       lt;
    } exp_t;
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] sel;
        exp_t       e;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] A = '0, B = '0, ALU_Out;
    logic [3:0] ALU_Sel = '0;
    logic       equal, greater, smaller, CarryOut;
    int         checks = 0, errors = 0, cyc_n = 0;
    string      phase = "init";
    exp_t       q[$];
    vec_t       tbl[$];

    alu8_struct dut (.clk(clk), .rst_n(rst_n), .A(A), .B(B), .ALU_Sel(ALU_Sel), .ALU_Out(ALU_Out),
                     .equal(equal), .greater(greater), .smaller(smaller), .CarryOut(CarryOut));

    always #5 clk = ~clk;

    function automatic exp_t mask(exp_t e);
        exp_t m = e;
        m.eq = e.eq & FL;
        m.gt = e.gt & FL;
        m.lt = e.lt & FL;
        return m;
    endfunction

    function automatic exp_t model(int a, int b, int sel);
        int r = 0;
        bit c = 0;
        exp_t e;
        case (sel)
            0, 4:  begin r = a + b; c = r > 255; end
            1, 5:  begin r = a - b + 256; c = a < b; end
            3, 7:  begin r = 256 - b; c = b == 0; end
            8:     r = a & b;
            9:     r = a ^ b;
            10:    r = a | b;
            11:    r = 255 - b;
            12:    r = a / 2;
            13:    r = a * 2;
            14:    r = a / 2 + (a % 2) * 128;
            15:    r = a * 2 + a / 128;
            default: r = 0;
        endcase
        r = r % 256;
        e.r = 8'(r);
        e.c = c;
        e.eq = a == b;
        e.gt = a > b;
        e.lt = a < b;
        return e;
    endfunction

    task automatic cyc(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s, input logic r, input exp_t e);
        exp_t want, got;
        @(negedge clk);
        A = a; B = b; ALU_Sel = s; rst_n = r;
        @(posedge clk);
        cyc_n++;
        if (r) begin
            q.delete();
            repeat (LAT) q.push_back('0);
            want = '0;
        end else begin
            q.push_back(mask(e));
            want = q.pop_front();
        end
        #1;
        got = {ALU_Out, CarryOut, equal, greater, smaller};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle %0d: got out=%h c=%b eq=%b gt=%b lt=%b, expected out=%h c=%b eq=%b gt=%b lt=%b",
                     phase, cyc_n, got.r, got.c, got.eq, got.gt, got.lt, want.r, want.c, want.eq, want.gt, want.lt);
        end
    endtask

    task automatic rnd_op(input logic r);
        logic [7:0] a, b;
        logic [3:0] s;
        a = 8'($urandom);
        b = ($urandom_range(0, 7) == 0) ? a : 8'($urandom);
        s = 4'($urandom);
        cyc(a, b, s, r, model(a, b, s));
    endtask

    initial begin
        logic [7:0] sw [16] = '{8'h18, 8'h10, 8'h00, 8'hFC, 8'h18, 8'h10, 8'h00, 8'hFC,
                                8'h04, 8'h10, 8'h14, 8'hFB, 8'h0A, 8'h28, 8'h0A, 8'h28};
        logic [3:0] rot_sel [4] = '{4'd14, 4'd15, 4'd12, 4'd13};
        logic [7:0] rot_res [4] = '{8'hC0, 8'h03, 8'h40, 8'h02};
        for (int i = 0; i < 16; i++)
            tbl.push_back('{8'h14, 8'h04, 4'(i), '{sw[i], 1'b0, 1'b0, 1'b1, 1'b0}});
        tbl.push_back('{8'h0A, 8'hF6, 4'd0, '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1}});
        tbl.push_back('{8'h0A, 8'hF6, 4'd1, '{8'h14, 1'b1, 1'b0, 1'b0, 1'b1}});
        tbl.push_back('{8'h5A, 8'h5A, 4'd1, '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0}});
        for (int i = 0; i < 4; i++)
            tbl.push_back('{8'h81, 8'h00, rot_sel[i], '{rot_res[i], 1'b0, 1'b0, 1'b1, 1'b0}});

        phase = "reset";
        repeat (2) rnd_op(1'b1);
        phase = "post_reset";
        for (int i = 0; i < LAT; i++) rnd_op(1'b0);

        phase = "table";
        foreach (tbl[i]) cyc(tbl[i].a, tbl[i].b, tbl[i].sel, 1'b0, tbl[i].e);
        phase = "table_drain";
        for (int i = 0; i < LAT; i++) rnd_op(1'b0);

        phase = "midflight_reset";
        for (int i = 0; i < 3; i++) rnd_op(1'b0);
        rnd_op(1'b1);
        for (int i = 0; i < LAT + 4; i++) rnd_op(1'b0);

        phase = "random";
        for (int i = 0; i < 300; i++) rnd_op($urandom_range(0, 29) == 0);
        phase = "drain";
        for (int i = 0; i < LAT; i++) rnd_op(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu8_struct.md
# alu8_struct

Eight-bit pipelined arithmetic/logic unit with unsigned compare flags. It accepts one operation per clock and presents the result, carry and compare flags exactly 8 register stages later. It serves as the datapath ALU slice. Its fixed latency lets upstream logic pre-compute expected results and check them cycle by cycle.

## Interface
Parameters:
- `PIPE_STAGES`, default 8: total register stages from input to output, including the input register; legal range 1 to 16.

Ports:
- `clk`  in  1: single clock, rising-edge active.
- `rst_n`  in  1: reset, synchronous, active-high despite the `_n` suffix. When 1 at a rising edge, all stages clear.
- `A`  in  8: operand A.
- `B`  in  8: operand B.
- `ALU_Sel`  in  4: opcode.
- `ALU_Out`  out  8: result.
- `equal`  out  1: A == B, unsigned.
- `greater`  out  1: A > B, unsigned.
- `smaller`  out  1: A < B, unsigned.
- `CarryOut`  out  1: carry/borrow flag.

## Operation
The opcode selects the result as follows. All arithmetic is modulo 256.
- 0 and 4: A + B. CarryOut = bit 8 of the 9-bit sum.
- 1 and 5: A − B. CarryOut = borrow, which is 1 when A < B.
- 3 and 7: two's complement of B (~B + 1). CarryOut = 1 only when B == 0.
- 2 and 6: reserved. Result is 0x00 and CarryOut is 0.
- 8: A & B.
- 9: A ^ B.
- 10: A | B.
- 11: ~B.
- 12: A >> 1, logical, zero fill.
- 13: A << 1, zero fill.
- 14: rotate right, {A[0], A[7:1]}.
- 15: rotate left, {A[6:0], A[7]}.
- CarryOut is 0 for opcodes 8–15.

Compare flags:
- Computed from A and B for every opcode, regardless of ALU_Sel.
- Exactly one of equal, greater, smaller is 1.
- All three are 0 while the pipeline holds reset zeros.

No handshake: every clock edge samples a new operation, so throughput is one operation per cycle.

## Timing
- Inputs are sampled at rising edge N.
- The matching ALU_Out, CarryOut and flags are valid after rising edge N+7 (PIPE_STAGES − 1) and hold for one cycle.
- Combinational logic sits between the input register and the second stage. The remaining stages are pure delay.
- Reset values: every stage clears to 0, so ALU_Out = 0x00 and CarryOut, equal, greater and smaller are all 0.
- After reset deasserts, outputs stay 0 until the first sampled operation emerges 7 edges later.
- Reset asserted mid-operation flushes all in-flight operations. Nothing partial is ever emitted.
- Reset has priority over new input at the same edge.
- Inputs may change every cycle. Back-to-back operations emerge in order with no bubbles.

## Configuration
- Macro `ALU_CMP_FLAGS_EN`.
- Defined: equal, greater and smaller are computed and pipelined as described above.
- Undefined: the three flag ports are tied to 0 and their pipeline bits are not instantiated. ALU_Out and CarryOut are unaffected.

## Structure
- Shared package `alu8_pkg` holds:
  - the opcode localparams (OP_ADD, OP_SUB, OP_NEG, OP_AND, OP_XOR, OP_OR, OP_NOT, OP_SHR, OP_SHL, OP_ROR, OP_ROL);
  - a packed struct for the pipeline payload: result[7:0], carry, eq, gt, lt.
- One sub-module, `alu8_core`: purely combinational opcode decode plus adder, logic, shifter and comparator.
- The top level holds the input register and the PIPE_STAGES delay chain.

## Test plan
- Reset: hold reset for 2 edges with arbitrary inputs. All outputs are 0 during reset and for 7 edges after release.
- Latency and sweep: A=0x14, B=0x04, ALU_Sel stepping 0..15, one per cycle. Each result appears 7 edges after its sample edge. Expected results in order:
  - ALU_Sel 0–7: 0x18, 0x10, 0x00, 0xFC, 0x18, 0x10, 0x00, 0xFC.
  - ALU_Sel 8–15: 0x04, 0x10, 0x14, 0xFB, 0x0A, 0x28, 0x0A, 0x28.
  - Flags throughout: greater=1.
- Carry and borrow: A=0x0A, B=0xF6.
  - Opcode 0 → 0x00, CarryOut=1.
  - Opcode 1 → 0x14, CarryOut=1, smaller=1.
- Equality: A=B=0x5A with opcode 1 → 0x00, CarryOut=0, equal=1.
- Mid-flight reset: assert reset for one edge after 3 operations are issued. None of them ever appears; outputs remain 0 until fresh operations emerge.
- Rotate edges: A=0x81. Opcode 14 → 0xC0, opcode 15 → 0x03, opcode 12 → 0x40, opcode 13 → 0x02.
